// File: rtl/crank_wheel_gen.sv
// crank_wheel_gen: 60-2 style missing-tooth crank signal plus half-speed cam signal.
// Optional macro CRANK_GEN_ACCEL_EN ramps the latched tooth period toward tooth_period by accel_step.
module crank_wheel_gen #(
    parameter int TEETH   = 60,
    parameter int MISSING = 2,
    parameter int CAM_ON  = 4,
    parameter int CAM_OFF = 54
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [15:0] tooth_period,
    input  logic [15:0] accel_step,
    output logic        cap_out,
    output logic        cam_out,
    output logic [7:0]  tooth_idx,
    output logic        phase,
    output logic        rev_strobe,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int          N       = TEETH - MISSING;
    localparam logic [7:0]  LAST    = 8'(N - 1);
    localparam logic [17:0] GAP_MUL = 18'(MISSING + 1);
    localparam logic [15:0] P_MIN   = 16'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] cnt_q, cnt_d;
    logic [17:0] len_q, len_d;
    logic [15:0] per_q, per_d;
    logic [15:0] per_step, per_new;
    logic [7:0]  tooth_q, tooth_d;
    logic [7:0]  idx_new;
    logic        cap_q, cap_d;
    logic        cam_q, cam_d;
    logic        phase_q, phase_d;
    logic        rev_q, rev_d;
    logic        busy_q, busy_d;
    logic        running, slot_end, start_idle, new_slot, wrap;

    assign running    = (state_q != S_IDLE);
    assign slot_end   = running && (cnt_q == len_q - 18'd1);
    assign start_idle = (state_q == S_IDLE) && en;
    // A slot start either launches a new slot or, with en low, drops back to IDLE.
    assign new_slot   = start_idle || (slot_end && en);
    assign wrap       = slot_end && (tooth_q == LAST);
    assign idx_new    = (start_idle || tooth_q == LAST) ? 8'd0 : tooth_q + 8'd1;

`ifdef CRANK_GEN_ACCEL_EN
    always_comb begin
        per_step = per_q;
        if (per_q < tooth_period) begin
            per_step = ((tooth_period - per_q) > accel_step) ? per_q + accel_step : tooth_period;
        end else if (per_q > tooth_period) begin
            per_step = ((per_q - tooth_period) > accel_step) ? per_q - accel_step : tooth_period;
        end
    end
`else
    logic unused_accel;
    assign unused_accel = ^{accel_step, per_q};
    assign per_step     = tooth_period;
`endif

    assign per_new = (per_step < P_MIN) ? P_MIN : per_step;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= 18'd4;
            per_q   <= P_MIN;
            tooth_q <= '0;
            cap_q   <= 1'b0;
            cam_q   <= 1'b0;
            phase_q <= 1'b0;
            rev_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            per_q   <= per_d;
            tooth_q <= tooth_d;
            cap_q   <= cap_d;
            cam_q   <= cam_d;
            phase_q <= phase_d;
            rev_q   <= rev_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_RUN;
            end
            S_RUN, S_STOP: begin
                if (slot_end) state_d = en ? S_RUN : S_IDLE;
                else          state_d = en ? S_RUN : S_STOP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        len_d   = len_q;
        per_d   = per_q;
        tooth_d = tooth_q;
        cap_d   = cap_q;
        cam_d   = cam_q;
        phase_d = wrap ? ~phase_q : phase_q;
        rev_d   = 1'b0;
        busy_d  = (state_d != S_IDLE);
        if (new_slot) begin
            cnt_d   = '0;
            per_d   = per_new;
            len_d   = (idx_new == LAST) ? {2'b00, per_new} * GAP_MUL : {2'b00, per_new};
            tooth_d = idx_new;
            cap_d   = 1'b0;
            rev_d   = wrap;
            // Cam edges only in the odd revolution; fall has priority over rise.
            if (phase_d && int'(idx_new) == CAM_OFF) begin
                cam_d = 1'b0;
            end else if (phase_d && int'(idx_new) == CAM_ON) begin
                cam_d = 1'b1;
            end
        end else if (slot_end) begin
            cnt_d   = '0;
            tooth_d = '0;
            cap_d   = 1'b0;
        end else if (running) begin
            cnt_d = cnt_q + 18'd1;
            cap_d = (cnt_d >= (len_q >> 1));
        end
    end

    assign cap_out    = cap_q;
    assign cam_out    = cam_q;
    assign tooth_idx  = tooth_q;
    assign phase      = phase_q;
    assign rev_strobe = rev_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Directed bench for crank_wheel_gen: slot timing, gap, cam, stop, clamp, period change, async reset.
module tb_crank_wheel_gen;
    logic        clk;
    logic        nrst;
    logic        en;
    logic [15:0] tooth_period;
    logic [15:0] accel_step;
    logic        cap_out;
    logic        cam_out;
    logic [7:0]  tooth_idx;
    logic        phase;
    logic        rev_strobe;
    logic        busy;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    crank_wheel_gen dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .tooth_period (tooth_period),
        .accel_step   (accel_step),
        .cap_out      (cap_out),
        .cam_out      (cam_out),
        .tooth_idx    (tooth_idx),
        .phase        (phase),
        .rev_strobe   (rev_strobe),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst         = 1'b0;
        en           = 1'b0;
        tooth_period = 16'd64;
        accel_step   = 16'd0;
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic wait_cap(input logic val, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cap_out !== val && n < max);
    endtask

    task automatic wait_tooth(input int target, input int max, output int n, output int strobes);
        n = 0;
        strobes = 0;
        do begin
            tick();
            n++;
            if (rev_strobe === 1'b1) strobes++;
        end while (int'(tooth_idx) != target && n < max);
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (rev_strobe !== 1'b1 && n < max);
    endtask

    task automatic slot_len(input int max, output int n);
        logic [7:0] prev;
        prev = tooth_idx;
        n = 0;
        do begin
            tick();
            n++;
        end while (tooth_idx === prev && n < max);
    endtask

    task automatic test_reset();
        nrst         = 1'b0;
        en           = 1'b0;
        tooth_period = 16'd64;
        accel_step   = 16'd0;
        tick();
        tick();
        total++; if (cap_out !== 1'b0) begin bad++; $display("FAIL reset_cap got=%0d exp=0", cap_out); end
        total++; if (cam_out !== 1'b0) begin bad++; $display("FAIL reset_cam got=%0d exp=0", cam_out); end
        total++; if (tooth_idx !== 8'd0) begin bad++; $display("FAIL reset_tooth got=%0d exp=0", tooth_idx); end
        total++; if (phase !== 1'b0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        total++; if (rev_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%0d exp=0", rev_strobe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        nrst = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0d exp=0", busy); end
    endtask

    task automatic test_basic();
        int n;
        int s;
        do_reset();
        en = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0d exp=1", busy); end
        total++; if (tooth_idx !== 8'd0) begin bad++; $display("FAIL start_tooth got=%0d exp=0", tooth_idx); end
        total++; if (cap_out !== 1'b0) begin bad++; $display("FAIL start_cap got=%0d exp=0", cap_out); end
        total++; if (rev_strobe !== 1'b0) begin bad++; $display("FAIL start_strobe got=%0d exp=0", rev_strobe); end
        wait_cap(1'b1, 200, n);
        total++; if (n != 32) begin bad++; $display("FAIL first_rise got=%0d exp=32", n); end
        wait_cap(1'b0, 200, n);
        total++; if (n != 32) begin bad++; $display("FAIL first_fall got=%0d exp=32", n); end
        total++; if (tooth_idx !== 8'd1) begin bad++; $display("FAIL tooth1 got=%0d exp=1", tooth_idx); end
        wait_tooth(57, 5000, n, s);
        total++; if (n != 3584) begin bad++; $display("FAIL to_gap got=%0d exp=3584", n); end
        total++; if (s != 0) begin bad++; $display("FAIL initial_strobe got=%0d exp=0", s); end
        wait_cap(1'b1, 400, n);
        total++; if (n != 96) begin bad++; $display("FAIL gap_rise got=%0d exp=96", n); end
        wait_cap(1'b0, 400, n);
        total++; if (n != 96) begin bad++; $display("FAIL gap_fall got=%0d exp=96", n); end
        total++; if (tooth_idx !== 8'd0) begin bad++; $display("FAIL wrap_tooth got=%0d exp=0", tooth_idx); end
        total++; if (rev_strobe !== 1'b1) begin bad++; $display("FAIL wrap_strobe got=%0d exp=1", rev_strobe); end
        total++; if (phase !== 1'b1) begin bad++; $display("FAIL wrap_phase got=%0d exp=1", phase); end
        tick();
        total++; if (rev_strobe !== 1'b0) begin bad++; $display("FAIL strobe_width got=%0d exp=0", rev_strobe); end
        wait_strobe(5000, n);
        total++; if (n + 1 != 3840) begin bad++; $display("FAIL strobe_spacing got=%0d exp=3840", n + 1); end
        total++; if (phase !== 1'b0) begin bad++; $display("FAIL wrap2_phase got=%0d exp=0", phase); end
    endtask

    task automatic test_cam();
        int cycles;
        int cam_hi;
        int rise_t;
        int fall_t;
        int rise_ok;
        int fall_ok;
        logic prev_cam;
        logic [7:0] prev_tooth;
        do_reset();
        en = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) begin
            cycles = 0;
            cam_hi = 0;
            rise_t = -1;
            fall_t = -1;
            rise_ok = 0;
            fall_ok = 0;
            prev_cam = cam_out;
            prev_tooth = tooth_idx;
            do begin
                tick();
                cycles++;
                if (cam_out === 1'b1) cam_hi++;
                if (cam_out === 1'b1 && prev_cam === 1'b0) begin
                    rise_t = int'(tooth_idx);
                    rise_ok = (tooth_idx !== prev_tooth) ? 1 : 0;
                end
                if (cam_out === 1'b0 && prev_cam === 1'b1) begin
                    fall_t = int'(tooth_idx);
                    fall_ok = (tooth_idx !== prev_tooth) ? 1 : 0;
                end
                prev_cam = cam_out;
                prev_tooth = tooth_idx;
            end while (rev_strobe !== 1'b1 && cycles < 5000);
            total++; if (cycles != 3840) begin bad++; $display("FAIL cam_rev_len r=%0d got=%0d exp=3840", r, cycles); end
            total++; if (cam_hi != ((r % 2 == 1) ? 3200 : 0)) begin bad++; $display("FAIL cam_high r=%0d got=%0d exp=%0d", r, cam_hi, (r % 2 == 1) ? 3200 : 0); end
            total++; if (rise_t != ((r % 2 == 1) ? 4 : -1)) begin bad++; $display("FAIL cam_rise_tooth r=%0d got=%0d", r, rise_t); end
            total++; if (fall_t != ((r % 2 == 1) ? 54 : -1)) begin bad++; $display("FAIL cam_fall_tooth r=%0d got=%0d", r, fall_t); end
            total++; if (rise_ok != r % 2) begin bad++; $display("FAIL cam_rise_at_start r=%0d got=%0d exp=%0d", r, rise_ok, r % 2); end
            total++; if (fall_ok != r % 2) begin bad++; $display("FAIL cam_fall_at_start r=%0d got=%0d exp=%0d", r, fall_ok, r % 2); end
            total++; if (int'(phase) != (r + 1) % 2) begin bad++; $display("FAIL cam_phase r=%0d got=%0d exp=%0d", r, phase, (r + 1) % 2); end
        end
    endtask

    task automatic test_stop();
        int n;
        int s;
        int hi;
        do_reset();
        en = 1'b1;
        tick();
        wait_tooth(5, 1000, n, s);
        repeat (5) tick();
        en = 1'b0;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy got=%0d exp=1", busy); end
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL stop_state got=%0d exp=2", dbg_state); end
        tick();
        tick();
        en = 1'b1;
        wait_tooth(6, 200, n, s);
        total++; if (n != 56) begin bad++; $display("FAIL resume_slot got=%0d exp=56", n); end
        wait_strobe(5000, n);
        wait_tooth(20, 2000, n, s);
        repeat (10) tick();
        en = 1'b0;
        n = 0;
        hi = 0;
        do begin
            tick();
            n++;
            if (cap_out === 1'b1) hi++;
        end while (busy !== 1'b0 && n < 500);
        total++; if (n != 54) begin bad++; $display("FAIL stop_drain got=%0d exp=54", n); end
        total++; if (hi != 32) begin bad++; $display("FAIL stop_high got=%0d exp=32", hi); end
        total++; if (cap_out !== 1'b0) begin bad++; $display("FAIL stop_cap got=%0d exp=0", cap_out); end
        total++; if (phase !== 1'b1) begin bad++; $display("FAIL stop_phase got=%0d exp=1", phase); end
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", busy); end
        en = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%0d exp=1", busy); end
        total++; if (tooth_idx !== 8'd0) begin bad++; $display("FAIL restart_tooth got=%0d exp=0", tooth_idx); end
        total++; if (phase !== 1'b1) begin bad++; $display("FAIL restart_phase got=%0d exp=1", phase); end
        wait_cap(1'b1, 200, n);
        total++; if (n != 32) begin bad++; $display("FAIL restart_rise got=%0d exp=32", n); end
    endtask

    task automatic test_clamp_period();
        int n;
        do_reset();
        tooth_period = 16'd2;
        en = 1'b1;
        tick();
        wait_cap(1'b1, 50, n);
        total++; if (n != 2) begin bad++; $display("FAIL clamp_rise got=%0d exp=2", n); end
        wait_cap(1'b0, 50, n);
        total++; if (n != 2) begin bad++; $display("FAIL clamp_fall got=%0d exp=2", n); end
        total++; if (tooth_idx !== 8'd1) begin bad++; $display("FAIL clamp_tooth got=%0d exp=1", tooth_idx); end
        tooth_period = 16'd64;
        wait_cap(1'b1, 50, n);
        total++; if (n != 2) begin bad++; $display("FAIL latch_rise got=%0d exp=2", n); end
        wait_cap(1'b0, 50, n);
        total++; if (n != 2) begin bad++; $display("FAIL latch_fall got=%0d exp=2", n); end
        repeat (40) tick();
        total++; if (cap_out !== 1'b1) begin bad++; $display("FAIL mid_cap got=%0d exp=1", cap_out); end
        tooth_period = 16'd32;
        wait_cap(1'b0, 200, n);
        total++; if (n != 24) begin bad++; $display("FAIL change_rest got=%0d exp=24", n); end
        total++; if (tooth_idx !== 8'd3) begin bad++; $display("FAIL change_tooth got=%0d exp=3", tooth_idx); end
        wait_cap(1'b1, 200, n);
        total++; if (n != 16) begin bad++; $display("FAIL new_rise got=%0d exp=16", n); end
        wait_cap(1'b0, 200, n);
        total++; if (n != 16) begin bad++; $display("FAIL new_fall got=%0d exp=16", n); end
    endtask

    task automatic test_async_reset();
        int n;
        int s;
        do_reset();
        en = 1'b1;
        tick();
        wait_tooth(30, 3000, n, s);
        repeat (40) tick();
        total++; if (cap_out !== 1'b1) begin bad++; $display("FAIL pre_reset_cap got=%0d exp=1", cap_out); end
        #2;
        nrst = 1'b0;
        #1;
        total++; if (cap_out !== 1'b0) begin bad++; $display("FAIL async_cap got=%0d exp=0", cap_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%0d exp=0", busy); end
        total++; if (tooth_idx !== 8'd0) begin bad++; $display("FAIL async_tooth got=%0d exp=0", tooth_idx); end
        tick();
        nrst = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rerun_busy got=%0d exp=1", busy); end
        total++; if (tooth_idx !== 8'd0) begin bad++; $display("FAIL rerun_tooth got=%0d exp=0", tooth_idx); end
        wait_cap(1'b1, 200, n);
        total++; if (n != 32) begin bad++; $display("FAIL rerun_rise got=%0d exp=32", n); end
    endtask

`ifdef CRANK_GEN_ACCEL_EN
    task automatic test_accel();
        int n;
        int up_tab [11] = '{14, 24, 34, 44, 54, 64, 74, 84, 94, 100, 100};
        int dn_tab [7]  = '{100, 90, 80, 70, 60, 50, 50};
        do_reset();
        tooth_period = 16'd100;
        accel_step   = 16'd10;
        en = 1'b1;
        tick();
        for (int i = 0; i < 11; i++) begin
            slot_len(500, n);
            total++; if (n != up_tab[i]) begin bad++; $display("FAIL accel_up i=%0d got=%0d exp=%0d", i, n, up_tab[i]); end
        end
        tooth_period = 16'd50;
        for (int i = 0; i < 7; i++) begin
            slot_len(500, n);
            total++; if (n != dn_tab[i]) begin bad++; $display("FAIL accel_dn i=%0d got=%0d exp=%0d", i, n, dn_tab[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_cam();
        test_stop();
        test_clamp_period();
        test_async_reset();
`ifdef CRANK_GEN_ACCEL_EN
        test_accel();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
